// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs field bundles into 32-bit words, tags each with a
// sequential write address and an error flag, and streams them through a 2-entry FIFO.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] word_count,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_func3,
  input  logic [6:0]  in_func7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic        busy,
  output logic        done,
  output logic [1:0]  state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and ready here comes only from registered state.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q;
  logic [15:0] wc_q;
  logic [15:0] acc_cnt_q;
  logic [31:0] addr_q;
  logic        done_q;
  logic [64:0] fifo_q [2];
  logic [1:0]  fifo_cnt_q;
  logic        rd_ptr_q;
  logic        wr_ptr_q;

  logic        push;
  logic        pop;
  logic        last_accept;
  logic        i_rng;
  logic        b_rng;
  logic        j_rng;
  logic        fmt_ok;
  logic        imm_ok;
  logic [31:0] enc_word;
  logic [31:0] enc_instr_d;
  logic        enc_err_d;

  assign in_ready    = (state_q == RUN) && (fifo_cnt_q != 2'd2);
  assign out_valid   = (fifo_cnt_q != 2'd0);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign last_accept = push && (acc_cnt_q == wc_q - 16'd1);

  assign out_instr = fifo_q[rd_ptr_q][31:0];
  assign out_addr  = fifo_q[rd_ptr_q][63:32];
  assign out_err   = fifo_q[rd_ptr_q][64];
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign state_dbg = state_q;

  // An immediate fits when every bit above its top field bit is a copy of the sign.
  assign i_rng = (in_imm[31:11] == 21'h0) || (in_imm[31:11] == 21'h1F_FFFF);
  assign b_rng = (in_imm[31:12] == 20'h0) || (in_imm[31:12] == 20'hF_FFFF);
  assign j_rng = (in_imm[31:20] == 12'h0) || (in_imm[31:20] == 12'hFFF);

  always_comb begin
    fmt_ok   = 1'b1;
    imm_ok   = 1'b1;
    enc_word = 32'h0;
    case (in_opcode)
      7'b0110011: enc_word = {in_func7, in_rs2, in_rs1, in_func3, in_rd, in_opcode};
      7'b0010011, 7'b0000011, 7'b1100111: begin
        enc_word = {in_imm[11:0], in_rs1, in_func3, in_rd, in_opcode};
        imm_ok   = i_rng;
      end
      7'b0100011: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], in_opcode};
        imm_ok   = i_rng;
      end
      7'b1100011: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                    in_imm[4:1], in_imm[11], in_opcode};
        imm_ok   = b_rng && !in_imm[0];
      end
      7'b1101111: begin
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        imm_ok   = j_rng && !in_imm[0];
      end
      7'b0110111, 7'b0010111: begin
        enc_word = {in_imm[31:12], in_rd, in_opcode};
        imm_ok   = (in_imm[11:0] == 12'h0);
      end
      default: fmt_ok = 1'b0;
    endcase
    enc_err_d   = !(fmt_ok && imm_ok);
    enc_instr_d = enc_err_d ? NOP : enc_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wc_q       <= 16'h0;
      acc_cnt_q  <= 16'h0;
      addr_q     <= 32'h0;
      done_q     <= 1'b0;
      fifo_cnt_q <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= 65'h0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q    <= base_addr;
            wc_q      <= word_count;
            acc_cnt_q <= 16'h0;
            if (word_count == 16'h0) done_q  <= 1'b1;
            else                     state_q <= RUN;
          end
        end
        RUN: begin
          if (push) begin
            addr_q    <= addr_q + 32'd4;
            acc_cnt_q <= acc_cnt_q + 16'd1;
            if (last_accept) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_cnt_q == 2'd0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (push) begin
        fifo_q[wr_ptr_q] <= {enc_err_d, addr_q, enc_instr_d};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule
